// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: stall/flush bit
// positions, fetch FSM encoding and reset/NOP constants.
package ifu_fetch_pkg;

    localparam int STALL_PC     = 0;
    localparam int STALL_PRE_IF = 1;
    localparam int STALL_IF_ID  = 2;
    localparam int STALL_ID_EX  = 3;
    localparam int STALL_EX_MEM = 4;
    localparam int STALL_MEM_WB = 5;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_e;

    // A fetch is outstanding from request issue until its response returns.
    function automatic logic is_fetch_busy(fetch_state_e st);
        return (st == ST_REQ) || (st == ST_WAIT);
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-RAM port: valid/ready request channel plus a valid-only
// response channel. The fetch unit is the master.
interface ifu_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [INST_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_err
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the PC and the Pre_IF instruction buffer,
// issues one instruction-RAM request at a time and hands words to IF_ID.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic [5:0]        flush_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    ifu_fetch_if.master       imem,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_err_o,
    output logic              ram_stall_valid_if_o,
    output logic              if_rdata_valid_o
);

    fetch_state_e      state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic              discard_r, discard_s;
    logic              capture_s;
    logic              handshake_s;

    logic              req_valid_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic              inst_valid_r;
    logic [INST_W-1:0] inst_r;
    logic [ADDR_W-1:0] inst_pc_r;
    logic              inst_err_r;
    logic              ram_stall_r;

    logic              unused_s;
    assign unused_s = ^{stall_i[5:2], flush_i[5:2], flush_i[0]};

    assign handshake_s = req_valid_r & imem.req_ready;

    // Next-state, next-PC and discard decisions for the fetch FSM.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        discard_s = discard_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_REQ;
                if (redirect_valid_i) begin
                    pc_s = redirect_pc_i;
                end else begin
                    pc_s = pc_r;
                end
            end
            ST_REQ: begin
                // A redirect racing the handshake lets the old request go out
                // but marks its response for dropping.
                if (handshake_s) begin
                    state_s   = ST_WAIT;
                    discard_s = redirect_valid_i;
                end else begin
                    state_s   = ST_REQ;
                    discard_s = 1'b0;
                end
                if (redirect_valid_i) begin
                    pc_s = redirect_pc_i;
                end else begin
                    pc_s = pc_r;
                end
            end
            ST_WAIT: begin
                if (imem.resp_valid) begin
                    discard_s = 1'b0;
                    if (discard_r || redirect_valid_i) begin
                        state_s = ST_REQ;
                        if (redirect_valid_i) begin
                            pc_s = redirect_pc_i;
                        end else begin
                            pc_s = pc_r;
                        end
                    end else begin
                        state_s   = ST_VALID;
                        capture_s = 1'b1;
                        if (stall_i[STALL_PC]) begin
                            pc_s = pc_r;
                        end else begin
                            pc_s = pc_r + ADDR_W'(32'd4);
                        end
                    end
                end else if (redirect_valid_i) begin
                    state_s   = ST_WAIT;
                    discard_s = 1'b1;
                    pc_s      = redirect_pc_i;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_VALID: begin
                if (redirect_valid_i) begin
                    state_s = ST_REQ;
                    pc_s    = redirect_pc_i;
                end else if (flush_i[STALL_PRE_IF]) begin
                    // Flush without a new target: refetch the dropped word.
                    state_s = ST_REQ;
                    pc_s    = inst_pc_r;
                end else if (stall_i[STALL_PRE_IF]) begin
                    state_s = ST_VALID;
                end else begin
                    state_s = ST_REQ;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                discard_s = 1'b0;
            end
        endcase
    end

    // FSM state, PC and discard flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            discard_r <= discard_s;
        end
    end

    // Registered request and status outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_r  <= 1'b0;
            req_addr_r   <= {ADDR_W{1'b0}};
            inst_valid_r <= 1'b0;
            ram_stall_r  <= 1'b0;
        end else begin
            req_valid_r  <= (state_s == ST_REQ);
            req_addr_r   <= (state_s == ST_REQ) ? pc_s : {ADDR_W{1'b0}};
            inst_valid_r <= (state_s == ST_VALID);
            ram_stall_r  <= is_fetch_busy(state_s);
        end
    end

    // Pre_IF instruction buffer, loaded when a kept response returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_r     <= {INST_W{1'b0}};
            inst_pc_r  <= {ADDR_W{1'b0}};
            inst_err_r <= 1'b0;
        end else if (capture_s) begin
            inst_r     <= imem.resp_data;
            inst_pc_r  <= pc_r;
            inst_err_r <= imem.resp_err;
        end else begin
            inst_r     <= inst_r;
            inst_pc_r  <= inst_pc_r;
            inst_err_r <= inst_err_r;
        end
    end

    assign imem.req_valid       = req_valid_r;
    assign imem.req_addr        = req_addr_r;
    assign inst_valid_o         = inst_valid_r;
    assign if_rdata_valid_o     = inst_valid_r;
    assign inst_o               = inst_r;
    assign inst_pc_o            = inst_pc_r;
    assign inst_err_o           = inst_err_r;
    assign ram_stall_valid_if_o = ram_stall_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a cycle table for the directed scenarios, a reset
// abandonment sequence, then random traffic against a transaction-level model.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [5:0]  flush;
    logic        redir;
    logic [31:0] redir_pc;
    logic        inst_valid, inst_err, ram_stall, rdata_valid;
    logic [31:0] inst, inst_pc;

    int n_checks = 0;
    int n_pass   = 0;

    ifu_fetch_if #(.ADDR_W(32), .INST_W(32)) imem_bus ();

    ifu_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h8000_0000)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall_i              (stall),
        .flush_i              (flush),
        .redirect_valid_i     (redir),
        .redirect_pc_i        (redir_pc),
        .imem                 (imem_bus.master),
        .inst_valid_o         (inst_valid),
        .inst_o               (inst),
        .inst_pc_o            (inst_pc),
        .inst_err_o           (inst_err),
        .ram_stall_valid_if_o (ram_stall),
        .if_rdata_valid_o     (rdata_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic [5:0]  flush;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        rsp;
        logic [31:0] rdata;
        logic        rerr;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_ierr;
        logic        e_rs;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic [5:0] st, logic [5:0] fl, logic rd, logic [31:0] rpc,
                                logic rdy, logic rsp, logic [31:0] rdata, logic rerr,
                                logic e_rv, logic [31:0] e_addr, logic e_iv, logic [31:0] e_inst,
                                logic [31:0] e_ipc, logic e_ierr, logic e_rs);
        vec_t v;
        v.stall = st;   v.flush = fl;   v.rd = rd;         v.rpc = rpc;
        v.rdy = rdy;    v.rsp = rsp;    v.rdata = rdata;   v.rerr = rerr;
        v.e_rv = e_rv;  v.e_addr = e_addr; v.e_iv = e_iv;  v.e_inst = e_inst;
        v.e_ipc = e_ipc; v.e_ierr = e_ierr; v.e_rs = e_rs;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] st, input logic [5:0] fl, input logic rd, input logic [31:0] rpc,
                         input logic rdy, input logic rsp, input logic [31:0] rdata, input logic rerr);
        stall = st; flush = fl; redir = rd; redir_pc = rpc;
        imem_bus.req_ready  = rdy;
        imem_bus.resp_valid = rsp;
        imem_bus.resp_data  = rdata;
        imem_bus.resp_err   = rerr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory contents and fault map used by the random phase.
    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic mem_err(logic [31:0] a);
        return (a[4:2] == 3'b110);
    endfunction

    // Transaction-level model state.
    logic [31:0] exp_pc, out_addr, buf_pc, buf_inst, p_tgt, tgt;
    logic        buf_err, buf_valid, outstanding, out_discard, started, exp_req;
    logic        p_req, p_ready, p_redir, p_flush1, p_stall1, p_stall0, p_resp;
    logic        got_cap, flushed;
    int          resp_timer;
    logic        r_rdy, r_rd, r_rsp;
    logic [5:0]  r_st, r_fl;

    initial begin
        rst = 1'b1;
        drive(6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Directed cycle table; row k = expected outputs of cycle k, inputs during cycle k.
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_0000, 1'b0,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        for (int k = 0; k < 4; k++) begin
            tv.push_back(mk(6'b000011, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b0, 32'h0, 1'b1, 32'h1111_0000, 32'h8000_0000, 1'b0, 1'b0));
        end
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b0, 32'h0, 1'b1, 32'h1111_0000, 32'h8000_0000, 1'b0, 1'b0));
        for (int k = 0; k < 5; k++) begin
            tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,  1'b1, 32'h8000_0004, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        end
        tv.push_back(mk(6'b000000, 6'b000010, 1'b1, 32'h8000_0200, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h8000_0004, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0004, 1'b0,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h8000_0200, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000010, 1'b1, 32'h8000_0100, 1'b1, 1'b0, 32'h0, 1'b0,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h8000_0100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2222_0100, 1'b0,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b0, 32'h0, 1'b1, 32'h2222_0100, 32'h8000_0100, 1'b0, 1'b0));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h8000_0100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3333_0100, 1'b0,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000010, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0,  1'b0, 32'h0, 1'b1, 32'h3333_0100, 32'h8000_0100, 1'b0, 1'b0));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4444_FFFC, 1'b1,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b0, 32'h0, 1'b1, 32'h4444_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0));
        tv.push_back(mk(6'b000000, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            check("t_req_valid", i, 32'(imem_bus.req_valid), 32'(tv[i].e_rv));
            if (tv[i].e_rv || i == 0) check("t_req_addr", i, imem_bus.req_addr, tv[i].e_addr);
            check("t_inst_valid", i, 32'(inst_valid), 32'(tv[i].e_iv));
            check("t_rdata_valid", i, 32'(rdata_valid), 32'(tv[i].e_iv));
            check("t_ram_stall", i, 32'(ram_stall), 32'(tv[i].e_rs));
            if (tv[i].e_iv || i == 0) begin
                check("t_inst", i, inst, tv[i].e_inst);
                check("t_inst_pc", i, inst_pc, tv[i].e_ipc);
                check("t_inst_err", i, 32'(inst_err), 32'(tv[i].e_ierr));
            end
            drive(tv[i].stall, tv[i].flush, tv[i].rd, tv[i].rpc, tv[i].rdy, tv[i].rsp, tv[i].rdata, tv[i].rerr);
            tick();
        end

        // Reset while a fetch is outstanding; late responses must be ignored.
        check("s_wait_req", 0, 32'(imem_bus.req_valid), 32'd0);
        check("s_wait_busy", 0, 32'(ram_stall), 32'd1);
        rst = 1'b1;
        drive(6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        check("s_rst_req", 1, 32'(imem_bus.req_valid), 32'd0);
        check("s_rst_addr", 1, imem_bus.req_addr, 32'd0);
        check("s_rst_iv", 1, 32'(inst_valid), 32'd0);
        check("s_rst_busy", 1, 32'(ram_stall), 32'd0);
        check("s_rst_inst", 1, inst, 32'd0);
        check("s_rst_pc", 1, inst_pc, 32'd0);
        drive(6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0000, 1'b1);
        tick();
        for (int k = 2; k < 4; k++) begin
            check("s_late_req", k, 32'(imem_bus.req_valid), 32'd1);
            check("s_late_addr", k, imem_bus.req_addr, 32'h8000_0000);
            check("s_late_iv", k, 32'(inst_valid), 32'd0);
            tick();
        end
        drive(6'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Random phase against the transaction-level model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_pc = 32'h8000_0000; started = 1'b0; outstanding = 1'b0; buf_valid = 1'b0;
        out_discard = 1'b0; out_addr = 32'h0; buf_pc = 32'h0; buf_inst = 32'h0; buf_err = 1'b0;
        p_req = 1'b0; p_ready = 1'b0; p_redir = 1'b0; p_flush1 = 1'b0; p_stall1 = 1'b0;
        p_stall0 = 1'b0; p_resp = 1'b0; p_tgt = 32'h0; resp_timer = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                got_cap = 1'b0;
                flushed = 1'b0;
                if (buf_valid) begin
                    if (p_redir || p_flush1 || !p_stall1) buf_valid = 1'b0;
                    flushed = !p_redir && p_flush1;
                end else if (outstanding) begin
                    if (p_resp) begin
                        outstanding = 1'b0;
                        if (!out_discard && !p_redir) begin
                            buf_valid = 1'b1; buf_pc = out_addr;
                            buf_inst = mem_word(out_addr); buf_err = mem_err(out_addr);
                            got_cap = 1'b1;
                        end
                    end else if (p_redir) begin
                        out_discard = 1'b1;
                    end
                end else if (p_req && p_ready) begin
                    outstanding = 1'b1; out_addr = exp_pc; out_discard = p_redir;
                    resp_timer = $urandom_range(0, 2);
                end
                if (p_redir) exp_pc = p_tgt;
                else if (flushed) exp_pc = buf_pc;
                else if (got_cap && !p_stall0) exp_pc = out_addr + 32'd4;
                started = 1'b1;
            end
            exp_req = started && !outstanding && !buf_valid;

            check("r_req_valid", c, 32'(imem_bus.req_valid), 32'(exp_req));
            if (exp_req) check("r_req_addr", c, imem_bus.req_addr, exp_pc);
            check("r_inst_valid", c, 32'(inst_valid), 32'(buf_valid));
            check("r_rdata_valid", c, 32'(rdata_valid), 32'(buf_valid));
            check("r_ram_stall", c, 32'(ram_stall), 32'(exp_req || outstanding));
            if (buf_valid) begin
                check("r_inst", c, inst, buf_inst);
                check("r_inst_pc", c, inst_pc, buf_pc);
                check("r_inst_err", c, 32'(inst_err), 32'(buf_err));
            end

            r_rdy = ($urandom_range(0, 3) != 0);
            r_rd  = started && ($urandom_range(0, 9) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
            tgt[1:0] = 2'b00;
            r_st  = 6'($urandom);
            r_st[1] = ($urandom_range(0, 2) == 0);
            r_st[0] = ($urandom_range(0, 3) == 0);
            r_fl  = 6'($urandom);
            r_fl[1] = r_rd || ($urandom_range(0, 9) == 0);
            r_rsp = 1'b0;
            if (outstanding) begin
                if (resp_timer == 0) r_rsp = 1'b1;
                else resp_timer--;
            end
            drive(r_st, r_fl, r_rd, tgt, r_rdy, r_rsp,
                  r_rsp ? mem_word(out_addr) : 32'($urandom), r_rsp ? mem_err(out_addr) : 1'b0);

            p_req = exp_req; p_ready = r_rdy; p_redir = r_rd; p_tgt = tgt;
            p_flush1 = r_fl[1]; p_stall1 = r_st[1]; p_stall0 = r_st[0]; p_resp = r_rsp;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction-fetch front end. Holds the PC (stall/flush bit 0) and the Pre_IF instruction buffer (bit 1) of the 6-bit stall/flush vector: 0=PC, 1=Pre_IF, 2=IF_ID, 3=ID_EX, 4=EX_MEM, 5=MEM_WB.
- Issues one request at a time to the instruction RAM over a valid/ready request channel and a valid response channel.
- Presents the fetched instruction to the IF_ID register.
- Drives the IF-stall and fetch-data-valid inputs of the pipeline control unit and consumes its stall/flush vectors.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
ADDR_W, 32, PC / address width
INST_W, 32, instruction width

Ports:
clk  in  1  clock
rst  in  1  reset
stall_i  in  6  stall vector from pipeline control
flush_i  in  6  flush vector from pipeline control
redirect_valid_i  in  1  jump/trap redirect, one-cycle pulse
redirect_pc_i  in  ADDR_W  redirect target
imem_req_valid_o  out  1  fetch request valid
imem_req_addr_o  out  ADDR_W  fetch address
imem_req_ready_i  in  1  RAM accepts request
imem_resp_valid_i  in  1  response data valid, one-cycle pulse
imem_resp_data_i  in  INST_W  instruction word
imem_resp_err_i  in  1  access fault on this response
inst_valid_o  out  1  instruction buffered for IF_ID
inst_o  out  INST_W  buffered instruction
inst_pc_o  out  ADDR_W  PC of buffered instruction
inst_err_o  out  1  buffered instruction faulted
ram_stall_valid_if_o  out  1  fetch outstanding (to control ram_stall_valid_if_i)
if_rdata_valid_o  out  1  equals inst_valid_o (to control if_rdata_valid_i)

Behaviour:
Reset (rst is synchronous, active-high):
- pc_q=RESET_PC, state=IDLE, discard_q=0.
- All outputs 0; inst_o, inst_pc_o = 0.
- rst mid-transaction abandons the transaction. Any response arriving after rst deasserts is ignored until a new request is accepted.

FSM states: IDLE, REQ, WAIT, VALID.
- IDLE: exactly one cycle after reset, then REQ.
- REQ:
  - imem_req_valid_o=1, imem_req_addr_o=pc_q.
  - Address stays stable until handshake (valid & ready).
  - On handshake -> WAIT.
- WAIT:
  - Hold until imem_resp_valid_i.
  - If discard_q=1: drop the response, clear discard_q -> REQ with updated pc_q.
  - Otherwise: inst_o=data, inst_pc_o=pc_q, inst_err_o=err, pc_q<=pc_q+4 (wraps modulo 2^ADDR_W) -> VALID.
- VALID:
  - inst_valid_o=1.
  - Consumed in a cycle where stall_i[1]=0 and flush_i[1]=0. On consumption -> REQ, next cycle presenting pc_q.
  - While stall_i[1]=1, instruction, PC and state hold.
- ram_stall_valid_if_o=1 exactly in REQ and WAIT.
- stall_i[0]=1 freezes pc_q updates from sequential increment only. It never blocks a redirect or an in-flight response capture.

Redirect / flush (redirect_valid_i is always accompanied by flush_i[1]=1):
- In REQ before handshake: pc_q<=redirect_pc_i; address changes next cycle. This is the only legal address change while valid is high.
- In REQ in the same cycle as handshake: request proceeds with the old address, discard_q<=1, pc_q<=redirect_pc_i.
- In WAIT: discard_q<=1, pc_q<=redirect_pc_i.
- If the response arrives in the same cycle as the redirect, it is discarded: state -> REQ and discard_q stays 0.
- In VALID: inst_valid_o<=0, pc_q<=redirect_pc_i -> REQ.
- Redirect overrides stall_i in all states.
- flush_i[1] without redirect, in VALID: drop the buffer, pc_q<=inst_pc_o (refetch the same instruction) -> REQ.
- flush_i[1] without redirect, in REQ/WAIT: no effect.
- Back-to-back redirects: the last one wins. discard_q is a single bit because only one request is ever outstanding.

Throughput: minimum 3 cycles per instruction (REQ, WAIT, VALID) with zero-wait RAM. No prefetch overlap.

Decomposition:
- Shared package: stall/flush bit-index constants (PC=0, PRE_IF=1, IF_ID=2, ID_EX=3, EX_MEM=4, MEM_WB=5), FSM state encoding, RESET_PC default, NOP encoding 32'h0000_0013.
- No sub-module. A single module containing the FSM, pc_q and the buffer register is natural.

Test Plan:
- Reset release, RAM always ready, responses 1 cycle after accept -> first request addr 32'h8000_0000 at cycle 1 after reset; inst_valid_o at cycle 3 with inst_pc_o=32'h8000_0000; next request addr 32'h8000_0004.
- Hold stall_i=6'b000011 for 4 cycles in VALID -> inst_o, inst_pc_o, inst_valid_o unchanged; no request issued; resumes REQ the cycle after stall drops.
- Redirect to 32'h8000_0100 while in WAIT, then response 32'hDEAD_BEEF -> response dropped, inst_valid_o stays 0; next request addr 32'h8000_0100.
- Redirect in the same cycle as request handshake -> old address request completes and is discarded; following request uses the redirect address; only one outstanding request at any time.
- imem_req_ready_i low for 5 cycles -> imem_req_addr_o stable; ram_stall_valid_if_o=1 throughout; if_rdata_valid_o=0.
- Response with imem_resp_err_i=1 at pc 32'hFFFF_FFFC -> inst_err_o=1, inst_valid_o=1; next fetch addr wraps to 32'h0000_0000.
